// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: sequential stall/flush controller for the IF, ID, EX and MEM
// pipeline registers. It handles load-use bubbles of configurable depth,
// stall-until-done for the multi-cycle EX unit, branch flushes, a global
// memory freeze, and two saturating performance counters.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no hazard pending; look at mc start / jump / load-use inputs
// ST_LOAD_WAIT | extra load-use bubbles owed; wait_cnt_q counts them down
// ST_MC_BUSY | multi-cycle EX op running; hold front end until ex_mc_done
//
// Only ST_IDLE reacts to ex_mc_start. In ST_LOAD_WAIT, EX holds a bubble, so
// no multi-cycle op can be starting there.
// LOAD_USE_STALL must be in 1..15 because wait_cnt is four bits wide.
module hazard_ctrl_mc #(
  parameter int REG_IDX_W      = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_reg1_idx,
  input  logic [REG_IDX_W-1:0] id_reg2_idx,
  input  logic                 id_uses_reg1,
  input  logic                 id_uses_reg2,
  input  logic [REG_IDX_W-1:0] ex_reg_wr_idx,
  input  logic                 ex_do_mem_read_en,
  input  logic                 pc_jump_enable,
  input  logic                 ex_mc_start,
  input  logic                 ex_mc_done,
  input  logic                 mem_stall,
  output logic                 hazard_fe_enable,
  output logic                 hazard_if_id_enable,
  output logic                 hazard_if_id_clear,
  output logic                 hazard_id_ex_enable,
  output logic                 hazard_id_ex_clear,
  output logic                 hazard_ex_mem_enable,
  output logic                 hazard_ex_mem_clear,
  output logic                 hazard_busy,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MC_BUSY   = 2'd2
  } state_t;

  // Extra bubbles that follow the first one, which is issued from ST_IDLE.
  localparam logic [3:0] WAIT_INIT = 4'(LOAD_USE_STALL - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       ld_haz;
  logic       flush_inc;

  // Load-use hazard: an ID source matches the load destination in EX. x0 is excluded.
  always_comb begin
    ld_haz = ex_do_mem_read_en && (ex_reg_wr_idx != '0) &&
             ((id_uses_reg1 && (id_reg1_idx == ex_reg_wr_idx)) ||
              (id_uses_reg2 && (id_reg2_idx == ex_reg_wr_idx)));
  end

  // State and bubble-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and pipeline control outputs. Reset and mem_stall override everything else.
  always_comb begin
    state_d              = state_q;
    wait_cnt_d           = wait_cnt_q;
    flush_inc            = 1'b0;
    hazard_fe_enable     = 1'b1;
    hazard_if_id_enable  = 1'b1;
    hazard_if_id_clear   = 1'b0;
    hazard_id_ex_enable  = 1'b1;
    hazard_id_ex_clear   = 1'b0;
    hazard_ex_mem_enable = 1'b1;
    hazard_ex_mem_clear  = 1'b0;

    if (!rst_n || mem_stall) begin
      hazard_fe_enable     = 1'b0;
      hazard_if_id_enable  = 1'b0;
      hazard_id_ex_enable  = 1'b0;
      hazard_ex_mem_enable = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_mc_start && !ex_mc_done) begin
            hazard_fe_enable    = 1'b0;
            hazard_if_id_enable = 1'b0;
            hazard_id_ex_enable = 1'b0;
            hazard_ex_mem_clear = 1'b1;
            state_d             = ST_MC_BUSY;
          end else if (pc_jump_enable) begin
            hazard_if_id_clear = 1'b1;
            hazard_id_ex_clear = 1'b1;
            flush_inc          = 1'b1;
          end else if (ld_haz) begin
            hazard_fe_enable    = 1'b0;
            hazard_if_id_enable = 1'b0;
            hazard_id_ex_clear  = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              wait_cnt_d = WAIT_INIT;
              state_d    = ST_LOAD_WAIT;
            end
          end
        end

        ST_LOAD_WAIT: begin
          hazard_fe_enable    = 1'b0;
          hazard_if_id_enable = 1'b0;
          hazard_id_ex_clear  = 1'b1;
          wait_cnt_d          = wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end

        ST_MC_BUSY: begin
          if (ex_mc_done) begin
            state_d = ST_IDLE;
          end else begin
            hazard_fe_enable    = 1'b0;
            hazard_if_id_enable = 1'b0;
            hazard_id_ex_enable = 1'b0;
            hazard_ex_mem_clear = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Busy whenever a multi-cycle hazard is in progress.
  always_comb begin
    hazard_busy = (state_q != ST_IDLE);
  end

  // Saturating counters for stalled fetch cycles and taken branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!hazard_fe_enable && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc. Two instances share the same stimulus: one with
// single-bubble load-use and 16-bit counters, and one with three bubbles and
// 2-bit counters so that counter saturation is reached quickly. Each instance
// is compared against a model that tracks owed bubbles and a pending
// multi-cycle flag.
module tb_hazard_ctrl_mc;

  localparam logic [6:0] O_DEF = 7'b1101010;  // {fe,ifid_en,ifid_clr,idex_en,idex_clr,exm_en,exm_clr}
  localparam logic [6:0] O_OFF = 7'b0000000;
  localparam logic [6:0] O_LD  = 7'b0001110;
  localparam logic [6:0] O_MC  = 7'b0000011;
  localparam logic [6:0] O_FL  = 7'b1111110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_reg1_idx, id_reg2_idx, ex_reg_wr_idx;
  logic       id_uses_reg1, id_uses_reg2, ex_do_mem_read_en;
  logic       pc_jump_enable, ex_mc_start, ex_mc_done, mem_stall;

  logic [6:0]  out_a, out_b;
  logic        busy_a, busy_b;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  stall_b, flush_b;

  int checks = 0;
  int failures = 0;

  int lus [2] = '{1, 3};
  int cmax[2] = '{65535, 3};
  int m_ld_left[2];
  bit m_mc[2];
  int m_stall[2];
  int m_flush[2];

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_IDX_W(5), .LOAD_USE_STALL(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .id_reg1_idx(id_reg1_idx), .id_reg2_idx(id_reg2_idx),
    .id_uses_reg1(id_uses_reg1), .id_uses_reg2(id_uses_reg2),
    .ex_reg_wr_idx(ex_reg_wr_idx), .ex_do_mem_read_en(ex_do_mem_read_en),
    .pc_jump_enable(pc_jump_enable), .ex_mc_start(ex_mc_start),
    .ex_mc_done(ex_mc_done), .mem_stall(mem_stall),
    .hazard_fe_enable(out_a[6]), .hazard_if_id_enable(out_a[5]),
    .hazard_if_id_clear(out_a[4]), .hazard_id_ex_enable(out_a[3]),
    .hazard_id_ex_clear(out_a[2]), .hazard_ex_mem_enable(out_a[1]),
    .hazard_ex_mem_clear(out_a[0]), .hazard_busy(busy_a),
    .stall_cycles(stall_a), .flush_count(flush_a)
  );

  hazard_ctrl_mc #(.REG_IDX_W(5), .LOAD_USE_STALL(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .id_reg1_idx(id_reg1_idx), .id_reg2_idx(id_reg2_idx),
    .id_uses_reg1(id_uses_reg1), .id_uses_reg2(id_uses_reg2),
    .ex_reg_wr_idx(ex_reg_wr_idx), .ex_do_mem_read_en(ex_do_mem_read_en),
    .pc_jump_enable(pc_jump_enable), .ex_mc_start(ex_mc_start),
    .ex_mc_done(ex_mc_done), .mem_stall(mem_stall),
    .hazard_fe_enable(out_b[6]), .hazard_if_id_enable(out_b[5]),
    .hazard_if_id_clear(out_b[4]), .hazard_id_ex_enable(out_b[3]),
    .hazard_id_ex_clear(out_b[2]), .hazard_ex_mem_enable(out_b[1]),
    .hazard_ex_mem_clear(out_b[0]), .hazard_busy(busy_b),
    .stall_cycles(stall_b), .flush_count(flush_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Model: the expected outputs for this cycle, and the effect of the next clock edge on the model.
  task automatic model_eval(input int k, input logic hz, output logic [6:0] exp, output logic ebusy);
    ebusy = (m_ld_left[k] > 0) || m_mc[k];
    if (!rst_n) begin
      exp = O_OFF;
      ebusy = 1'b0;
    end else if (mem_stall) begin
      exp = O_OFF;
      m_stall[k] = sat_inc(m_stall[k], cmax[k]);
    end else if (m_mc[k]) begin
      if (ex_mc_done) begin
        exp = O_DEF;
        m_mc[k] = 1'b0;
      end else begin
        exp = O_MC;
        m_stall[k] = sat_inc(m_stall[k], cmax[k]);
      end
    end else if (m_ld_left[k] > 0) begin
      exp = O_LD;
      m_ld_left[k]--;
      m_stall[k] = sat_inc(m_stall[k], cmax[k]);
    end else if (ex_mc_start && !ex_mc_done) begin
      exp = O_MC;
      m_mc[k] = 1'b1;
      m_stall[k] = sat_inc(m_stall[k], cmax[k]);
    end else if (pc_jump_enable) begin
      exp = O_FL;
      m_flush[k] = sat_inc(m_flush[k], cmax[k]);
    end else if (hz) begin
      exp = O_LD;
      m_ld_left[k] = lus[k] - 1;
      m_stall[k] = sat_inc(m_stall[k], cmax[k]);
    end else begin
      exp = O_DEF;
    end
  endtask

  // Drive a cycle's inputs, then check both instances against the model.
  task automatic step(input logic rst, input logic ms, input logic jmp, input logic st,
                      input logic dn, input logic ld, input logic u1, input logic u2,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr);
    logic       hz;
    logic [6:0] exp;
    logic       ebusy;
    @(negedge clk);
    rst_n = rst; mem_stall = ms; pc_jump_enable = jmp; ex_mc_start = st;
    ex_mc_done = dn; ex_do_mem_read_en = ld; id_uses_reg1 = u1; id_uses_reg2 = u2;
    id_reg1_idx = r1; id_reg2_idx = r2; ex_reg_wr_idx = wr;
    #1;
    hz = ld && (wr != 5'd0) && ((u1 && (r1 == wr)) || (u2 && (r2 == wr)));
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_ld_left[k] = 0; m_mc[k] = 1'b0; m_stall[k] = 0; m_flush[k] = 0;
      end
    end
    check_val("a_stall_cnt", 32'(stall_a), 32'(m_stall[0]));
    check_val("a_flush_cnt", 32'(flush_a), 32'(m_flush[0]));
    check_val("b_stall_cnt", 32'(stall_b), 32'(m_stall[1]));
    check_val("b_flush_cnt", 32'(flush_b), 32'(m_flush[1]));
    model_eval(0, hz, exp, ebusy);
    check_val("a_outputs", 32'(out_a), 32'(exp));
    check_val("a_busy", 32'(busy_a), 32'(ebusy));
    model_eval(1, hz, exp, ebusy);
    check_val("b_outputs", 32'(out_b), 32'(exp));
    check_val("b_busy", 32'(busy_b), 32'(ebusy));
  endtask

  task automatic idle_step();
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 0; pc_jump_enable = 0; ex_mc_start = 0; ex_mc_done = 0;
    ex_do_mem_read_en = 0; id_uses_reg1 = 0; id_uses_reg2 = 0;
    id_reg1_idx = '0; id_reg2_idx = '0; ex_reg_wr_idx = '0;
    for (int k = 0; k < 2; k++) begin
      m_ld_left[k] = 0; m_mc[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end

    // Reset, then quiet pipeline without a hazard.
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    step(1, 0, 0, 0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3);
    // Load-use on reg1, then with a destination of x0.
    step(1, 0, 0, 0, 0, 1, 1, 0, 5'd5, 5'd2, 5'd5);
    idle_step(); idle_step(); idle_step();
    step(1, 0, 0, 0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0);
    // Three-bubble wait with mem_stall in the middle.
    step(1, 0, 0, 0, 0, 1, 0, 1, 5'd1, 5'd7, 5'd7);
    step(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle_step(); idle_step(); idle_step();
    // Branch together with a load-use hazard.
    step(1, 0, 1, 0, 0, 1, 1, 0, 5'd4, 5'd2, 5'd4);
    idle_step();
    // Multi-cycle op: done four cycles after start, then start and done together.
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle_step(); idle_step(); idle_step();
    step(1, 0, 0, 0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    step(1, 0, 0, 1, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle_step();
    // Reset asserted while an op is busy.
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    idle_step();

    // Randomized traffic. Small register indices keep hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Sequential, parametrised successor to the pipeline's combinational hazard unit; owns all stall/flush control for IF, ID, EX and MEM.
- Adds configurable load-use bubble depth for multi-cycle data memory, and stall-until-done support for a multi-cycle EX unit (mul/div).
- Adds a global memory-not-ready freeze, per-stage enables and clears, and saturating performance counters.
- Sits between the ID/EX decode signals and the pipeline register enable/clear inputs.

Parameters:
- REG_IDX_W, 5: register index width.
- LOAD_USE_STALL, 1: bubbles inserted per load-use hazard. Legal range is 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_reg1_idx  in  REG_IDX_W  ID-stage source register 1.
- id_reg2_idx  in  REG_IDX_W  ID-stage source register 2.
- id_uses_reg1  in  1  ID instruction reads reg1.
- id_uses_reg2  in  1  ID instruction reads reg2.
- ex_reg_wr_idx  in  REG_IDX_W  EX-stage destination register.
- ex_do_mem_read_en  in  1  EX instruction is a load.
- pc_jump_enable  in  1  taken branch/jump resolved in EX.
- ex_mc_start  in  1  multi-cycle op present in EX this cycle (first cycle only).
- ex_mc_done  in  1  multi-cycle unit result valid.
- mem_stall  in  1  data memory not ready; freeze pipeline.
- hazard_fe_enable  out  1  PC/fetch advance.
- hazard_if_id_enable  out  1  IF/ID register load.
- hazard_if_id_clear  out  1  IF/ID register flush.
- hazard_id_ex_enable  out  1  ID/EX register load.
- hazard_id_ex_clear  out  1  ID/EX flush (bubble).
- hazard_ex_mem_enable  out  1  EX/MEM register load.
- hazard_ex_mem_clear  out  1  EX/MEM flush (bubble).
- hazard_busy  out  1  FSM not in IDLE.
- stall_cycles  out  CNT_W  cycles with hazard_fe_enable=0 (saturating).
- flush_count  out  CNT_W  branch flushes taken (saturating).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- While rst_n=0:
  - FSM is IDLE; wait_cnt=0; stall_cycles=0; flush_count=0.
  - All enables and all clears are forced to 0; hazard_busy=0.
- Default outputs (no event): all enables=1, all clears=0.
- Load-use detect (ld_haz), combinational:
  - ex_do_mem_read_en=1 and ex_reg_wr_idx!=0, and
  - (id_uses_reg1 and id_reg1_idx==ex_reg_wr_idx) or (id_uses_reg2 and id_reg2_idx==ex_reg_wr_idx).
  - x0 never creates a hazard.
- Priority, highest first: mem_stall, then MC_BUSY/ex_mc_start, then pc_jump_enable, then ld_haz/LOAD_WAIT.
- mem_stall=1:
  - All enables=0, all clears=0.
  - FSM, wait_cnt and flush_count hold; stall_cycles increments.
- FSM states: IDLE, LOAD_WAIT, MC_BUSY.
- IDLE, ex_mc_start=1 and ex_mc_done=0:
  - fe/if_id/id_ex enables=0; ex_mem_clear=1.
  - Next state MC_BUSY.
  - If ex_mc_done=1 in the same cycle, no stall and stay IDLE.
- IDLE, pc_jump_enable=1:
  - if_id_clear=1, id_ex_clear=1, fe_enable=1; flush_count increments.
  - Any ld_haz in the same cycle is ignored (wrong-path instruction).
- IDLE, ld_haz:
  - fe_enable=0, if_id_enable=0, id_ex_clear=1.
  - If LOAD_USE_STALL>1: wait_cnt<=LOAD_USE_STALL-1, next state LOAD_WAIT. Otherwise stay IDLE.
- LOAD_WAIT:
  - Same outputs as ld_haz.
  - wait_cnt decrements each non-frozen cycle; when wait_cnt==1, next state IDLE.
  - Total bubbles per hazard = LOAD_USE_STALL exactly.
  - pc_jump_enable and ld_haz are ignored in this state.
- MC_BUSY:
  - fe/if_id/id_ex enables=0; ex_mem_clear=1 (bubbles into MEM).
  - On ex_mc_done=1: default outputs this cycle (result advances), next state IDLE.
  - pc_jump_enable is ignored.
- hazard_busy=1 in LOAD_WAIT and MC_BUSY.
- Counters saturate at all-ones and never wrap.
- Reset mid-LOAD_WAIT or mid-MC_BUSY: immediate return to IDLE with counters cleared.
- All outputs are combinational from state and inputs. No output latency beyond this; state updates on the rising clk edge.

Test Plan:
- Reset, then no hazard: reg1=1, reg2=2, ex_wr=3, load=0 -> all enables=1, clears=0, busy=0, stall_cycles=0.
- Load-use with LOAD_USE_STALL=1: reg1=5, uses1=1, ex_wr=5, load=1 for 1 cycle -> fe=0, if_id_en=0, id_ex_clear=1 for 1 cycle; stall_cycles=1. Repeat with ex_wr=0 -> no stall.
- Load-use with LOAD_USE_STALL=3 -> exactly 3 stall cycles, busy=1 for cycles 2-3; mem_stall=1 mid-wait extends the stall by 1 with all enables=0.
- Branch: pc_jump=1 together with ld_haz -> if_id_clear=1, id_ex_clear=1, fe=1, no stall; flush_count=1.
- Multi-cycle op: ex_mc_start=1, ex_mc_done asserted 4 cycles later -> 4 stall cycles with ex_mem_clear=1, release on the done cycle; start+done in the same cycle -> 0 stall.
- Counters and reset: CNT_W=2 with 5 stalls -> stall_cycles=3 (saturated); rst_n low in MC_BUSY -> IDLE with counters=0 asynchronously.
